// File: rtl/mpu_seq_ctrl_if.sv
// Sequencer bus: program-memory fetch handshake plus datapath controls.
// master = sequencer, slave = memory/datapath side.
interface mpu_seq_ctrl_if;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] acc_next;
  logic [7:0] pc;
  logic [2:0] alu_sel;
  logic       acc_src;
  logic       acc_load;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic       zero;
  logic       halted;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  mem_rdata, mem_ready, acc_next,
    output pc, alu_sel, acc_src, acc_load, reg_we,
    output reg_addr, zero, halted, illegal, state
  );

  modport slave (
    output mem_rdata, mem_ready, acc_next,
    input  pc, alu_sel, acc_src, acc_load, reg_we,
    input  reg_addr, zero, halted, illegal, state
  );
endinterface

// File: rtl/mpu_seq_ctrl.sv
// Multicycle fetch/decode/execute sequencer for the 8-bit MPU.
// Owns PC, IR, zero flag and the ALU select register.
module mpu_seq_ctrl #(
  parameter logic [7:0] RESET_PC        = 8'h00,
  parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  mpu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_OPND   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_ir, w_ir_nxt;
  logic       r_zero, w_zero_nxt;
  logic [2:0] r_alu_sel, w_alu_sel_nxt;

  logic [3:0] w_op, w_fop;
  logic       w_is_alu, w_is_lda, w_is_sta;
  logic       w_acc_load, w_acc_src, w_reg_we, w_illegal;

  assign w_op     = r_ir[7:4];
  assign w_fop    = bus.mem_rdata[7:4];
  assign w_is_alu = (w_op >= 4'h1) && (w_op <= 4'h7);
  assign w_is_lda = (w_op == 4'h8);
  assign w_is_sta = (w_op == 4'h9);

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_zero_nxt    = r_zero;
    w_alu_sel_nxt = r_alu_sel;
    w_acc_load    = 1'b0;
    w_acc_src     = 1'b0;
    w_reg_we      = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_ir_nxt    = bus.mem_rdata;
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = S_DECODE;
          // ALU select is loaded with the fetch so it is valid in DECODE
          if ((w_fop >= 4'h1) && (w_fop <= 4'h7))
            w_alu_sel_nxt = bus.mem_rdata[6:4];
          else if (w_fop == 4'h9)
            w_alu_sel_nxt = 3'b000;
        end
      end
      S_DECODE: begin
        case (w_op)
          4'h0:             w_state_nxt = S_FETCH;
          4'hA, 4'hB:       w_state_nxt = S_OPND;
          4'hF:             w_state_nxt = S_HALT;
          4'hC, 4'hD, 4'hE: begin
            w_illegal   = 1'b1;
            w_state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
          default:          w_state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        unique case (1'b1)
          w_is_alu: w_acc_load = 1'b1;
          w_is_lda: begin
            w_acc_load = 1'b1;
            w_acc_src  = 1'b1;
          end
          w_is_sta: w_reg_we = 1'b1;
          default:  ;
        endcase
        if (w_acc_load)
          w_zero_nxt = (bus.acc_next == 8'h00);
      end
      S_OPND: begin
        if (bus.mem_ready) begin
          w_state_nxt = S_FETCH;
          if ((w_op == 4'hA) || r_zero)
            w_pc_nxt = bus.mem_rdata;
          else
            w_pc_nxt = r_pc + 8'd1;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 8'h00;
      r_zero    <= 1'b0;
      r_alu_sel <= 3'b000;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_zero    <= w_zero_nxt;
      r_alu_sel <= w_alu_sel_nxt;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.alu_sel  = r_alu_sel;
  assign bus.acc_src  = w_acc_src;
  assign bus.acc_load = w_acc_load;
  assign bus.reg_we   = w_reg_we;
  assign bus.reg_addr = r_ir[3:0];
  assign bus.zero     = r_zero;
  assign bus.halted   = (r_state == S_HALT);
  assign bus.illegal  = w_illegal;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_mpu_seq_ctrl.sv
// Directed bench for mpu_seq_ctrl; u0 runs illegal-as-NOP,
// u1 halts on illegal, both share memory and stimulus.
module tb_mpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [7:0] accn;
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mpu_seq_ctrl_if ifc0 ();
  mpu_seq_ctrl_if ifc1 ();

  assign ifc0.mem_rdata = mem[ifc0.pc];
  assign ifc0.mem_ready = ready;
  assign ifc0.acc_next  = accn;
  assign ifc1.mem_rdata = mem[ifc1.pc];
  assign ifc1.mem_ready = ready;
  assign ifc1.acc_next  = accn;

  mpu_seq_ctrl #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b0)) u0 (
    .clk(clk), .reset(reset), .bus(ifc0)
  );
  mpu_seq_ctrl #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b1)) u1 (
    .clk(clk), .reset(reset), .bus(ifc1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ready = 1'b1;
    accn  = 8'h05;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clr_mem();
    mem[0] = 8'h41;
    reset = 1'b1;
    ready = 1'b1;
    accn  = 8'h05;
    tick();
    checks++;
    if (ifc0.state !== 3'd0) begin
      errors++; $display("FAIL rst_state got %0d exp 0", ifc0.state);
    end
    checks++;
    if (ifc0.pc !== 8'h00) begin
      errors++; $display("FAIL rst_pc got %h exp 00", ifc0.pc);
    end
    checks++;
    if ({ifc0.zero, ifc0.halted, ifc0.illegal} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags got %b exp 000",
               {ifc0.zero, ifc0.halted, ifc0.illegal});
    end
    checks++;
    if ({ifc0.acc_load, ifc0.reg_we, ifc0.acc_src} !== 3'b000) begin
      errors++;
      $display("FAIL rst_strobes got %b exp 000",
               {ifc0.acc_load, ifc0.reg_we, ifc0.acc_src});
    end
    checks++;
    if (ifc0.alu_sel !== 3'b000) begin
      errors++; $display("FAIL rst_alu_sel got %b exp 000", ifc0.alu_sel);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_alu();
    clr_mem();
    mem[0] = 8'h41;
    do_reset();
    tick();
    checks++;
    if (ifc0.state !== 3'd1 || ifc0.pc !== 8'h01) begin
      errors++;
      $display("FAIL add_decode got st=%0d pc=%h exp st=1 pc=01",
               ifc0.state, ifc0.pc);
    end
    tick();
    checks++;
    if (ifc0.state !== 3'd2 || ifc0.alu_sel !== 3'b100 ||
        ifc0.reg_addr !== 4'h1 || ifc0.acc_load !== 1'b1 ||
        ifc0.acc_src !== 1'b0) begin
      errors++;
      $display("FAIL add_exec got st=%0d sel=%b ra=%h ld=%b src=%b",
               ifc0.state, ifc0.alu_sel, ifc0.reg_addr,
               ifc0.acc_load, ifc0.acc_src);
    end
    tick();
    checks++;
    if (ifc0.state !== 3'd0 || ifc0.pc !== 8'h01 ||
        ifc0.acc_load !== 1'b0 || ifc0.zero !== 1'b0) begin
      errors++;
      $display("FAIL add_next got st=%0d pc=%h ld=%b z=%b exp 0 01 0 0",
               ifc0.state, ifc0.pc, ifc0.acc_load, ifc0.zero);
    end
  endtask

  task automatic test_lda_inc_sta_hlt();
    logic bad;
    clr_mem();
    mem[0] = 8'h80; mem[1] = 8'h60; mem[2] = 8'h90; mem[3] = 8'hF0;
    do_reset();
    accn = 8'h00;
    tick();
    tick();
    checks++;
    if (ifc0.acc_load !== 1'b1 || ifc0.acc_src !== 1'b1) begin
      errors++;
      $display("FAIL lda_exec got ld=%b src=%b exp 1 1",
               ifc0.acc_load, ifc0.acc_src);
    end
    tick();
    checks++;
    if (ifc0.zero !== 1'b1) begin
      errors++; $display("FAIL lda_zero got %b exp 1", ifc0.zero);
    end
    accn = 8'h01;
    tick();
    tick();
    checks++;
    if (ifc0.alu_sel !== 3'b110 || ifc0.acc_load !== 1'b1 ||
        ifc0.acc_src !== 1'b0) begin
      errors++;
      $display("FAIL inc_exec got sel=%b ld=%b src=%b exp 110 1 0",
               ifc0.alu_sel, ifc0.acc_load, ifc0.acc_src);
    end
    tick();
    checks++;
    if (ifc0.zero !== 1'b0 || ifc0.pc !== 8'h02) begin
      errors++;
      $display("FAIL inc_zero got z=%b pc=%h exp 0 02", ifc0.zero, ifc0.pc);
    end
    tick();
    tick();
    checks++;
    if (ifc0.reg_we !== 1'b1 || ifc0.alu_sel !== 3'b000 ||
        ifc0.acc_load !== 1'b0 || ifc0.reg_addr !== 4'h0) begin
      errors++;
      $display("FAIL sta_exec got we=%b sel=%b ld=%b ra=%h",
               ifc0.reg_we, ifc0.alu_sel, ifc0.acc_load, ifc0.reg_addr);
    end
    tick();
    tick();
    tick();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc0.halted !== 1'b1 || ifc0.pc !== 8'h04 ||
          ifc0.state !== 3'd4 || ifc0.acc_load !== 1'b0 ||
          ifc0.reg_we !== 1'b0)
        bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0 || ifc0.pc !== 8'h04) begin
      errors++;
      $display("FAIL hlt_hold got halted=%b pc=%h exp 1 04",
               ifc0.halted, ifc0.pc);
    end
  endtask

  task automatic run_jz(input logic [7:0] lda_val,
                        input logic [7:0] exp_pc);
    clr_mem();
    mem[0] = 8'h80; mem[1] = 8'hA0; mem[2] = 8'h10;
    mem[8'h10] = 8'hB0; mem[8'h11] = 8'h40;
    do_reset();
    accn = lda_val;
    repeat (3) tick();
    repeat (3) tick();
    checks++;
    if (ifc0.pc !== 8'h10 || ifc0.state !== 3'd0) begin
      errors++;
      $display("FAIL jmp_10 got pc=%h st=%0d exp 10 0",
               ifc0.pc, ifc0.state);
    end
    tick();
    tick();
    checks++;
    if (ifc0.state !== 3'd3) begin
      errors++; $display("FAIL jz_opnd got st=%0d exp 3", ifc0.state);
    end
    tick();
    checks++;
    if (ifc0.pc !== exp_pc || ifc0.state !== 3'd0) begin
      errors++;
      $display("FAIL jz_target got pc=%h st=%0d exp %h 0",
               ifc0.pc, ifc0.state, exp_pc);
    end
  endtask

  task automatic test_jz();
    run_jz(8'h00, 8'h40);
    run_jz(8'h07, 8'h12);
  endtask

  task automatic test_jmp_wrap();
    clr_mem();
    mem[0] = 8'hA0; mem[1] = 8'hFF;
    mem[8'hFF] = 8'hA0; mem[8'hA0] = 8'hF0;
    do_reset();
    repeat (3) tick();
    checks++;
    if (ifc0.pc !== 8'hFF) begin
      errors++; $display("FAIL jmp_ff got pc=%h exp ff", ifc0.pc);
    end
    tick();
    checks++;
    if (ifc0.pc !== 8'h00 || ifc0.state !== 3'd1) begin
      errors++;
      $display("FAIL pc_wrap got pc=%h st=%0d exp 00 1",
               ifc0.pc, ifc0.state);
    end
    tick();
    tick();
    checks++;
    if (ifc0.pc !== 8'hA0) begin
      errors++; $display("FAIL wrap_target got pc=%h exp a0", ifc0.pc);
    end
  endtask

  task automatic test_stall();
    logic bad;
    clr_mem();
    mem[0] = 8'hA0; mem[1] = 8'h20; mem[8'h20] = 8'h41;
    do_reset();
    ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifc0.state !== 3'd0 || ifc0.pc !== 8'h00 ||
          ifc0.acc_load !== 1'b0 || ifc0.reg_we !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall got st=%0d pc=%h exp 0 00",
               ifc0.state, ifc0.pc);
    end
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifc0.state !== 3'd3 || ifc0.pc !== 8'h01 ||
          ifc0.acc_load !== 1'b0 || ifc0.reg_we !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL opnd_stall got st=%0d pc=%h exp 3 01",
               ifc0.state, ifc0.pc);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (ifc0.pc !== 8'h20 || ifc0.state !== 3'd0) begin
      errors++;
      $display("FAIL stall_resume got pc=%h st=%0d exp 20 0",
               ifc0.pc, ifc0.state);
    end
    tick();
    tick();
    checks++;
    if (ifc0.acc_load !== 1'b1 || ifc0.alu_sel !== 3'b100) begin
      errors++;
      $display("FAIL stall_exec got ld=%b sel=%b exp 1 100",
               ifc0.acc_load, ifc0.alu_sel);
    end
  endtask

  task automatic test_illegal();
    clr_mem();
    mem[0] = 8'hC3;
    do_reset();
    tick();
    checks++;
    if (ifc0.illegal !== 1'b1 || ifc1.illegal !== 1'b1) begin
      errors++;
      $display("FAIL ill_pulse got u0=%b u1=%b exp 1 1",
               ifc0.illegal, ifc1.illegal);
    end
    tick();
    checks++;
    if (ifc0.illegal !== 1'b0 || ifc0.state !== 3'd0 ||
        ifc0.pc !== 8'h01 || ifc0.halted !== 1'b0) begin
      errors++;
      $display("FAIL ill_nop got ill=%b st=%0d pc=%h exp 0 0 01",
               ifc0.illegal, ifc0.state, ifc0.pc);
    end
    checks++;
    if (ifc1.state !== 3'd4 || ifc1.halted !== 1'b1 ||
        ifc1.illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_halt got st=%0d h=%b ill=%b exp 4 1 0",
               ifc1.state, ifc1.halted, ifc1.illegal);
    end
  endtask

  task automatic test_reset_mid();
    clr_mem();
    mem[0] = 8'h80; mem[1] = 8'h41;
    do_reset();
    accn = 8'h00;
    repeat (3) tick();
    accn = 8'h09;
    tick();
    tick();
    checks++;
    if (ifc0.acc_load !== 1'b1 || ifc0.zero !== 1'b1 ||
        ifc0.pc !== 8'h02) begin
      errors++;
      $display("FAIL pre_rst got ld=%b z=%b pc=%h exp 1 1 02",
               ifc0.acc_load, ifc0.zero, ifc0.pc);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ifc0.acc_load !== 1'b0 || ifc0.pc !== 8'h00 ||
        ifc0.state !== 3'd0 || ifc0.zero !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got ld=%b pc=%h st=%0d z=%b exp 0 00 0 0",
               ifc0.acc_load, ifc0.pc, ifc0.state, ifc0.zero);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b1;
    accn  = 8'h05;
    clr_mem();
    test_reset();
    test_fetch_alu();
    test_lda_inc_sta_hlt();
    test_jz();
    test_jmp_wrap();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpu_seq_ctrl.md
Name: mpu_seq_ctrl

Overview:
- Multicycle sequencer for the 8-bit MPU datapath: accumulator, register file and the 3-bit-select ALU (pass A, AND, OR, NOT, ADD, SUB, INC, DEC).
- Owns PC and IR, fetches byte-wide instructions from program memory with a ready handshake, and decodes them.
- Drives ALU select, accumulator load/source, register write and the branch/halt control.
- Sits between program memory and the datapath.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ON_ILLEGAL, 0, 1 = an illegal opcode enters HALT; 0 = it executes as NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_rdata  in  8  program memory data at address pc, combinational.
- mem_ready  in  1  mem_rdata valid this cycle.
- acc_next  in  8  datapath value to be loaded into the accumulator; used for the zero flag.
- pc  out  8  program counter / memory address.
- alu_sel  out  3  ALU function select.
- acc_src  out  1  0 = accumulator loads the ALU output; 1 = it loads the register-file read data.
- acc_load  out  1  one-cycle accumulator write strobe.
- reg_we  out  1  one-cycle register-file write strobe; data is the ALU output with alu_sel=000.
- reg_addr  out  4  register index, = ir[3:0].
- zero  out  1  zero flag.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on decode of an undefined opcode.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async): state=FETCH(0), pc=RESET_PC, ir=0, zero=0.
  - All strobes, halted and illegal = 0; alu_sel=000; acc_src=0.
- Instruction encoding: opcode = ir[7:4], operand = ir[3:0].
  - 0 NOP; 1 AND Rn; 2 OR Rn; 3 NOT; 4 ADD Rn; 5 SUB Rn; 6 INC; 7 DEC.
  - 8 LDA Rn; 9 STA Rn; A JMP abs; B JZ abs; F HLT.
  - C, D, E are illegal.
  - JMP and JZ take a second byte: the absolute target.
- States: FETCH=0, DECODE=1, EXEC=2, OPND=3, HALT=4.
- FETCH:
  - Waits while mem_ready=0; pc and ir hold.
  - On mem_ready=1: ir<=mem_rdata, pc<=pc+1 (8-bit wrap, FF->00), go to DECODE.
- DECODE:
  - reg_addr is valid; alu_sel is preset to the EXEC value.
  - HLT -> HALT.
  - JMP/JZ -> OPND.
  - Illegal -> pulse illegal; go to HALT if HALT_ON_ILLEGAL, else FETCH.
  - NOP -> FETCH.
  - All others -> EXEC.
- EXEC (exactly one cycle), then FETCH:
  - Opcodes 1-7: alu_sel = opcode[2:0], acc_src=0, acc_load=1.
  - LDA: acc_src=1, acc_load=1.
  - STA: alu_sel=000, reg_we=1.
  - Whenever acc_load=1: zero <= (acc_next==0) at the same clock edge.
- OPND:
  - Waits on mem_ready.
  - On ready, JMP: pc<=mem_rdata.
  - On ready, JZ: pc<=mem_rdata if zero=1, else pc<=pc+1 (skip the operand byte).
  - Then FETCH. zero is unchanged by branches.
- HALT: halted=1, no strobes, pc frozen; exits only via reset.
- Latency, with ready always 1:
  - NOP: 2 cycles.
  - ALU ops, LDA, STA: 3 cycles.
  - JMP, JZ: 3 cycles.
- Outside their defined cycle: acc_load, reg_we and illegal = 0; alu_sel keeps its last value.
- Reset asserted mid-instruction: immediate return to reset values; a pending acc_load/reg_we is dropped.
- mem_ready is ignored outside FETCH and OPND.

Test Plan:
- Reset with memory 00:41, ready=1 -> state FETCH(0) -> DECODE(1) -> EXEC(2).
  - EXEC cycle: alu_sel=100, reg_addr=1, acc_load=1.
  - pc=01 after fetch; next fetch occurs at pc=01.
- Program 80,60,90,F0, acc_next=00 when LDA R0 executes, then 01 -> zero=1 after LDA, zero=0 after INC.
  - STA gives reg_we=1 with alu_sel=000.
  - HLT: halted=1 and pc stays at 04 for 20 cycles.
- JZ with zero=1, bytes B0 at 10 and 40 at 11 -> pc=40 after 3 cycles.
  - Same with zero=0 -> pc=12.
  - JMP at FF with operand at 00 -> pc wraps and then loads the target.
- mem_ready held low 5 cycles in FETCH, then in OPND -> state, pc, ir hold and no strobes during the stall; execution resumes correctly afterwards.
- Opcode C3:
  - HALT_ON_ILLEGAL=0 -> one-cycle illegal pulse, back to FETCH, pc=+1.
  - HALT_ON_ILLEGAL=1 -> HALT.
- reset asserted asynchronously during the EXEC of ADD -> acc_load drops immediately, pc=RESET_PC, state=0, zero=0.
